// File: rtl/ddc_agc_pkg.sv
// Shared types and constants for the ddc_agc gain control loop.
// Gains are 17-bit linear values where GAIN_UNITY is 1.0.
package ddc_agc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    UPDATE,
    NORMALIZE
  } state_t;

  localparam int DATA_W     = 15;
  localparam int GAIN_W     = 17;
  localparam int MAG_W      = 16;

  localparam int GAIN_UNITY = 65536;
  localparam int GAIN_MAX   = 131071;

  localparam logic [DATA_W-1:0] SAT_POS = 15'h3FFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 15'h4000;

  // A two's complement input of -16384 has magnitude 16384, so the result needs MAG_W bits.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [DATA_W-1:0] x);
    logic [MAG_W-1:0] ext;
    ext = {x[DATA_W-1], x};
    return x[DATA_W-1] ? ((~ext) + MAG_W'(1)) : ext;
  endfunction

endpackage

// File: rtl/ddc_agc_ctrl_if.sv
// Sample stream from ddc_agc together with the gain/shift feedback path back into it.
// The master side is ddc_agc itself and the slave side is the controller.
interface ddc_agc_ctrl_if;
  import ddc_agc_pkg::*;

  logic                  ddc_agc_data_vld;
  logic [DATA_W-1:0]     ddc_agc_data_i;
  logic [DATA_W-1:0]     ddc_agc_data_q;
  logic [GAIN_W-1:0]     ddc_agc_value;
  logic [1:0]            ddc_agc_6db_sel;

  modport master (
    output ddc_agc_data_vld,
    output ddc_agc_data_i,
    output ddc_agc_data_q,
    input  ddc_agc_value,
    input  ddc_agc_6db_sel
  );

  modport slave (
    input  ddc_agc_data_vld,
    input  ddc_agc_data_i,
    input  ddc_agc_data_q,
    output ddc_agc_value,
    output ddc_agc_6db_sel
  );

endinterface

// File: rtl/ddc_agc_ctrl_mag_acc.sv
// Windowed |I|+|Q| accumulator with a saturated-sample counter.
// window_done fires combinationally while the final sample of the window is being taken.
module agc_mag_acc
  import ddc_agc_pkg::*;
#(
  parameter int WIN_LOG2 = 10,
  parameter int SAT_LIM  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              acc_en,
  input  logic              vld,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] data_q,
  output logic              window_done,
  output logic [MAG_W-1:0]  mean,
  output logic              sat_hit
);

  localparam int ACC_W  = MAG_W + WIN_LOG2;
  localparam int SATC_W = WIN_LOG2 + 1;

  logic [ACC_W-1:0]    acc;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [SATC_W-1:0]   sat_cnt;
  logic [MAG_W-1:0]    mag;
  logic                sample_sat;
  logic                take;

  assign mag        = abs_mag(data_i) + abs_mag(data_q);
  assign sample_sat = (data_i == SAT_POS) || (data_i == SAT_NEG) ||
                      (data_q == SAT_POS) || (data_q == SAT_NEG);
  assign take        = acc_en && vld;
  assign window_done = take && (win_cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      win_cnt <= '0;
      sat_cnt <= '0;
    end else if (clear) begin
      acc     <= '0;
      win_cnt <= '0;
      sat_cnt <= '0;
    end else if (take) begin
      acc     <= acc + ACC_W'(mag);
      win_cnt <= win_cnt + WIN_LOG2'(1);
      if (sample_sat) begin
        sat_cnt <= sat_cnt + SATC_W'(1);
      end
    end
  end

  // The window length is a power of two, so the mean is just the upper bits of the sum.
  assign mean    = acc[ACC_W-1 -: MAG_W];
  assign sat_hit = 32'(sat_cnt) >= SAT_LIM;

endmodule

// File: rtl/ddc_agc_ctrl.sv
// Closed-loop AGC: measures the mean I/Q magnitude per window and steers the
// linear gain plus the 6 dB shift select fed back to ddc_agc.
module ddc_agc_ctrl
  import ddc_agc_pkg::*;
#(
  parameter int WIN_LOG2  = 10,
  parameter int ATTACK_SH = 3,
  parameter int DECAY_SH  = 5,
  parameter int SAT_LIM   = 8,
  parameter int GAIN_MIN  = 256,
  parameter int RST_VALUE = 65536
) (
  input  logic              ddc_agc_clk,
  input  logic              ddc_agc_rst,
  ddc_agc_ctrl_if.slave     agc_bus,
  input  logic              agc_en,
  input  logic              agc_freeze,
  input  logic [MAG_W-1:0]  agc_target_hi,
  input  logic [MAG_W-1:0]  agc_target_lo,
  input  logic [GAIN_W-1:0] agc_manual_value,
  input  logic [1:0]        agc_manual_sel,
  output logic              agc_update,
  output logic [MAG_W-1:0]  agc_mean,
  output logic              agc_sat_flag
);

  localparam int                CAND_W    = GAIN_W + 1;
  localparam logic [CAND_W-1:0] CAND_MAX  = CAND_W'(GAIN_MAX);
  localparam logic [CAND_W-1:0] CAND_UNIT = CAND_W'(GAIN_UNITY);
  localparam logic [CAND_W-1:0] CAND_MIN  = CAND_W'(GAIN_MIN);

  state_t            state, next_state;
  logic              window_done;
  logic [MAG_W-1:0]  win_mean;
  logic              sat_hit;
  logic              acc_clear;
  logic              acc_en;

  logic [GAIN_W-1:0] gain_q;
  logic [1:0]        sel_q;
  logic [CAND_W-1:0] cand_q;
  logic [CAND_W-1:0] cand_next;
  logic [CAND_W-1:0] norm_work;
  logic [GAIN_W-1:0] norm_val;
  logic [1:0]        norm_sel;
  logic [CAND_W-1:0] g_ext;

  assign acc_en    = (state == MEASURE) && agc_en;
  assign acc_clear = (state == IDLE) || (state == NORMALIZE) || !agc_en;

  agc_mag_acc #(
    .WIN_LOG2 (WIN_LOG2),
    .SAT_LIM  (SAT_LIM)
  ) u_mag_acc (
    .clk         (ddc_agc_clk),
    .rst         (ddc_agc_rst),
    .clear       (acc_clear),
    .acc_en      (acc_en),
    .vld         (agc_bus.ddc_agc_data_vld),
    .data_i      (agc_bus.ddc_agc_data_i),
    .data_q      (agc_bus.ddc_agc_data_q),
    .window_done (window_done),
    .mean        (win_mean),
    .sat_hit     (sat_hit)
  );

  always_ff @(posedge ddc_agc_clk or posedge ddc_agc_rst) begin
    if (ddc_agc_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (agc_en) next_state = MEASURE;
      MEASURE:   if (window_done) next_state = UPDATE;
      UPDATE:    next_state = NORMALIZE;
      NORMALIZE: next_state = MEASURE;
      default:   next_state = IDLE;
    endcase
    if (!agc_en) begin
      next_state = IDLE;
    end
  end

  // Saturation outranks the band check; hi outranks lo so an inverted band still attacks.
  always_comb begin
    g_ext = {1'b0, gain_q};
    if (sat_hit) begin
      cand_next = g_ext - (g_ext >> 1);
    end else if (win_mean > agc_target_hi) begin
      cand_next = g_ext - (g_ext >> ATTACK_SH);
    end else if (win_mean < agc_target_lo) begin
      cand_next = g_ext + (g_ext >> DECAY_SH);
    end else begin
      cand_next = g_ext;
    end
  end

  always_comb begin
    norm_work = cand_q;
    norm_sel  = sel_q;
    if (norm_work > CAND_MAX) begin
      if (sel_q != 2'd3) begin
        norm_sel  = sel_q + 2'd1;
        norm_work = norm_work >> 1;
      end else begin
        norm_work = CAND_MAX;
      end
    end else if ((norm_work < CAND_UNIT) && (sel_q != 2'd0)) begin
      norm_sel  = sel_q - 2'd1;
      norm_work = norm_work << 1;
    end
    if (norm_work < CAND_MIN) begin
      norm_work = CAND_MIN;
    end
    norm_val = norm_work[GAIN_W-1:0];
  end

  // Dropping agc_en hands the outputs straight back to the manual values on the next edge.
  always_ff @(posedge ddc_agc_clk or posedge ddc_agc_rst) begin
    if (ddc_agc_rst) begin
      gain_q       <= GAIN_W'(RST_VALUE);
      sel_q        <= 2'd0;
      agc_update   <= 1'b0;
      agc_mean     <= '0;
      agc_sat_flag <= 1'b0;
      cand_q       <= '0;
    end else begin
      agc_update <= 1'b0;
      if (!agc_en || (state == IDLE)) begin
        gain_q <= agc_manual_value;
        sel_q  <= agc_manual_sel;
      end else begin
        case (state)
          UPDATE: begin
            agc_mean     <= win_mean;
            agc_sat_flag <= sat_hit;
            cand_q       <= cand_next;
          end
          NORMALIZE: begin
            if (!agc_freeze) begin
              gain_q     <= norm_val;
              sel_q      <= norm_sel;
              agc_update <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign agc_bus.ddc_agc_value   = gain_q;
  assign agc_bus.ddc_agc_6db_sel = sel_q;

endmodule

// File: doc/ddc_agc_ctrl.md
Name: ddc_agc_ctrl

Overview:
Closed-loop gain controller for ddc_agc. It measures the mean magnitude of the ddc_agc output I/Q samples over a fixed window and compares it against a programmable target band. It then updates the 17-bit linear gain and the 6 dB shift select that ddc_agc consumes. It sits downstream of ddc_agc and feeds ddc_agc_value and ddc_agc_6db_sel back to it.

Parameters:
WIN_LOG2, 10, measurement window = 2^WIN_LOG2 valid samples
ATTACK_SH, 3, gain decrease step = g >> ATTACK_SH
DECAY_SH, 5, gain increase step = g >> DECAY_SH
SAT_LIM, 8, saturated-sample count per window that triggers fast attack (g halved)
GAIN_MIN, 256, lower clamp of ddc_agc_value
RST_VALUE, 65536, ddc_agc_value after reset

Ports:
ddc_agc_clk  in  1  clock
ddc_agc_rst  in  1  asynchronous reset, active-high
agc_en  in  1  1 = closed loop, 0 = manual
agc_freeze  in  1  hold gain; measurement continues
ddc_agc_data_vld  in  1  sample qualifier
ddc_agc_data_i  in  15  signed I from ddc_agc
ddc_agc_data_q  in  15  signed Q from ddc_agc
agc_target_hi  in  16  upper mean threshold, unsigned
agc_target_lo  in  16  lower mean threshold, unsigned
agc_manual_value  in  17  gain used when agc_en=0
agc_manual_sel  in  2  6 dB select used when agc_en=0
ddc_agc_value  out  17  gain to ddc_agc, registered
ddc_agc_6db_sel  out  2  6 dB select to ddc_agc, registered
agc_update  out  1  one-cycle pulse when a new gain is applied
agc_mean  out  16  last window mean, registered
agc_sat_flag  out  1  last window hit SAT_LIM

Behaviour:
- Reset (async): ddc_agc_value=RST_VALUE; ddc_agc_6db_sel=0; agc_update=0; agc_mean=0; agc_sat_flag=0; accumulators=0; state=IDLE.
- Magnitude: m = |I|+|Q|, 16-bit unsigned. |-16384| = 16384, so max m = 32768.
- Saturated sample: I or Q equal to 16383 or -16384.
- Accumulator width is 16+WIN_LOG2. Mean = acc >> WIN_LOG2, truncated.
- Only cycles with vld=1 in MEASURE accumulate. Samples arriving in UPDATE or NORMALIZE are dropped.
- States:
  - IDLE: outputs <= manual inputs every cycle; accumulators cleared. Goes to MEASURE when agc_en=1.
  - MEASURE: accumulate. On the 2^WIN_LOG2-th valid sample, go to UPDATE.
  - UPDATE: register agc_mean and agc_sat_flag, then compute the 18-bit candidate g' with this priority:
    - sat count >= SAT_LIM: g' = g - (g>>1)
    - else mean > hi: g' = g - (g>>ATTACK_SH)
    - else mean < lo: g' = g + (g>>DECAY_SH)
    - else g' = g
  - NORMALIZE: apply g' in this order:
    - g' > 131071 and sel<3: sel+1, g' >>= 1
    - g' > 131071 and sel=3: g' = 131071
    - g' < 65536 and sel>0: sel-1, g' <<= 1
    - finally clamp g' >= GAIN_MIN
    - Register ddc_agc_value and sel, pulse agc_update, clear accumulators, return to MEASURE.
- Latency: last window sample at cycle N -> agc_mean valid N+1 -> outputs and agc_update at N+2.
- agc_freeze=1 during NORMALIZE: gain and sel hold, no agc_update pulse; agc_mean and agc_sat_flag still update.
- agc_en=0 in any state: IDLE next cycle, partial window discarded, no pulse.
- Re-enable: the loop starts from the current (manual) outputs with a full new window.
- agc_target_lo > agc_target_hi: the hi comparison wins (priority above).
- At most one gain step per window; sel changes by at most ±1 per window.

Decomposition:
- Package ddc_agc_pkg:
  - state enum {IDLE, MEASURE, UPDATE, NORMALIZE}
  - DATA_W=15, GAIN_W=17, MAG_W=16
  - GAIN_UNITY=65536, GAIN_MAX=131071, SAT_POS=16383, SAT_NEG=-16384
- One sub-module, agc_mag_acc: abs-sum, window counter, accumulator, saturation counter. It outputs window_done, mean and sat_hit; ddc_agc_ctrl holds the FSM and gain arithmetic.

Test Plan:
(bench WIN_LOG2=4, ATTACK_SH=3, DECAY_SH=3, SAT_LIM=4, hi=6000, lo=4000)
1. Reset asserted mid-window -> immediately value=65536, sel=0, agc_update=0, agc_mean=0; after release and agc_en=1, a full 16-sample window is needed before any update.
2. agc_en=1, I=8000, Q=0 for 16 valid samples -> agc_mean=8000, value=57344, sel=0, agc_update pulse at N+2.
3. Manual 120000/sel 0, then agc_en=1, I=Q=1000 -> mean=2000 -> g'=135000 -> sel=1, value=67500.
4. Manual 65536/sel 2, I=16383 for 16 samples -> agc_sat_flag=1, g'=32768 -> sel=1, value=65536. Repeat from sel 0 -> value 32768, sel 0.
5. Manual 131071/sel 3, I=Q=500 -> g'=147454 -> value clamped 131071, sel 3. Same stimulus with agc_freeze=1 -> value unchanged, no pulse, agc_mean=1000.
6. agc_en dropped after 8 samples -> next cycle outputs equal manual inputs, no pulse. Re-enable -> first update only after 16 new valid samples; vld gaps extend the window correctly.
